seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. It decodes a packed hex word one nibble per digit and scans the digits at a programmable refresh rate. It inserts an inter-digit blanking gap to suppress ghosting, and updates the displayed value only at frame boundaries so a digit never shows a mix of old and new data. It sits between the register/bus fabric and the board display pins, and replaces per-digit static decoding.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 1000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 8, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 0, 1 inverts o_seg and o_dp.
- ANODE_ACTIVE_LOW, 0, 1 inverts o_an.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_data  in  4*NUM_DIGITS  hex value; nibble d drives digit d, and digit 0 is the least significant nibble.
- i_dp  in  NUM_DIGITS  decimal point per digit.
- i_load  in  1  one-cycle strobe that captures i_data and i_dp.
- o_seg  out  7  segments; bit0=a .. bit6=g.
- o_dp  out  1  decimal point of the active digit.
- o_an  out  NUM_DIGITS  digit enables, one-hot or all-off.
- o_frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (i_rst=1 at an edge) sets the following:
  - tick=0, digit=0.
  - pending and shadow registers = 0; pending_valid=0.
  - o_an all inactive, o_seg all inactive, o_dp inactive, o_frame_done=0.
  - "Inactive" means polarity per parameter.
- Reset mid-scan aborts the scan; the scan restarts at digit 0, tick 0 on the first edge with i_rst=0.
- Scan counters:
  - tick counts 0..REFRESH_DIV-1 each cycle; at REFRESH_DIV-1 it wraps to 0 and digit increments.
  - digit wraps NUM_DIGITS-1 -> 0.
  - With NUM_DIGITS=1, digit stays at 0.
- Outputs are registered and lag the counters by one cycle. For the cycle carrying (digit=d, tick=t):
  - t < BLANK_CYCLES: o_an all inactive, o_seg inactive, o_dp inactive.
  - Otherwise: o_an has only bit d active, o_seg = decode(shadow nibble d), o_dp = shadow_dp[d].
- Decode (active-high form): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:67 A:77 B:7C C:39 D:5E E:79 F:71.
- Frame boundary is the cycle with digit=NUM_DIGITS-1 and tick=REFRESH_DIV-1. At that edge:
  - o_frame_done is 1 for the following cycle.
  - If pending_valid=1, shadow <= pending and pending_valid <= 0.
- i_load:
  - Away from the frame boundary: pending <= {i_dp,i_data} and pending_valid <= 1.
  - Multiple loads within one frame: the last one wins.
  - i_load on the boundary cycle: shadow <= {i_dp,i_data} directly and pending_valid <= 0.
- Data becomes visible no earlier than the first slot of the next frame, and never within a partially scanned frame.
- i_data and i_dp are ignored when i_load=0.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit d>0 is suppressed (o_seg inactive) when its shadow nibble and all higher shadow nibbles are 0.
  - The anode is still scanned normally and o_dp still follows shadow_dp[d].
  - Digit 0 is never suppressed.
- Undefined: all digits decode normally, so zeros show 3F.

Test Plan:
- Setup for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, active-high polarity unless stated.
- Reset: hold i_rst=1 for 3 cycles -> o_an=0000, o_seg=00, o_dp=0, o_frame_done=0. On release, the digit-0 slot shows 1 blank cycle, then o_an=0001, o_seg=3F for 3 cycles.
- Load 16'h12AF, i_dp=4'b0100; wait for the frame boundary -> per slot:
  - Digit 0: o_an=0001, o_seg=71.
  - Digit 1: o_an=0010, o_seg=77.
  - Digit 2: o_an=0100, o_seg=5B, o_dp=1.
  - Digit 3: o_an=1000, o_seg=06.
  - o_frame_done pulses exactly once every 16 cycles.
- Tear-free update:
  - Load 16'h1111 during the digit-1 slot -> digits 2 and 3 still show 12AF values; the next frame shows 06 on all digits.
  - i_load on the boundary cycle -> the new value is shown starting at the immediately following digit-0 slot.
- Polarity: SEG_ACTIVE_LOW=1, ANODE_ACTIVE_LOW=1, data 16'h0008 -> digit-0 slot o_an=1110, o_seg=00; blank cycles o_an=1111, o_seg=7F.
- Reset mid-frame (during the digit-2 slot) -> outputs go inactive next cycle and shadow clears. The scan restarts at digit 0, showing 3F on all digits.
- Data 16'h0050:
  - With SEVEN_SEG_LEADING_ZERO_BLANK_EN: digits 3 and 2 have o_seg=00 with o_an still scanned; digit 1 = 6D; digit 0 = 3F.
  - Without the macro: digits 3 and 2 show 3F.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Scanned N-digit hex seven-segment driver with tear-free, frame-aligned updates.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 1000,
   parameter int BLANK_CYCLES     = 8,
   parameter bit SEG_ACTIVE_LOW   = 1'b0,
   parameter bit ANODE_ACTIVE_LOW = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [4*NUM_DIGITS-1:0] i_data,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic                    i_load,
   output logic [6:0]              o_seg,
   output logic                    o_dp,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic                    o_frame_done
);

   localparam int TW = $clog2(REFRESH_DIV);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
   localparam logic [TW-1:0] BLANK_T    = TW'(BLANK_CYCLES);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

   localparam logic SEG_INV = SEG_ACTIVE_LOW;
   localparam logic AN_INV  = ANODE_ACTIVE_LOW;

   logic [TW-1:0]             tick;
   logic [DW-1:0]             digit;
   logic                      slot_end;
   logic                      boundary;
   logic                      blank;

   logic [4*NUM_DIGITS-1:0]   shadow_data;
   logic [NUM_DIGITS-1:0]     shadow_dp;
   logic [4*NUM_DIGITS-1:0]   pend_data;
   logic [NUM_DIGITS-1:0]     pend_dp;
   logic                      pend_valid;

   logic [3:0]                cur_nib;
   logic                      cur_dp;
   logic [NUM_DIGITS-1:0]     slot_an;
   logic                      suppress;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] seg;
      unique case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h67;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
      endcase
      return seg;
   endfunction

   assign slot_end = (tick == TICK_LAST);
   assign boundary = slot_end && (digit == DIGIT_LAST);
   assign blank    = (tick < BLANK_T);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tick  <= '0;
         digit <= '0;
      end else if (slot_end) begin
         tick  <= '0;
         digit <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   // Shadow only changes at the frame edge, so a scan never mixes two values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shadow_data <= '0;
         shadow_dp   <= '0;
         pend_data   <= '0;
         pend_dp     <= '0;
         pend_valid  <= 1'b0;
      end else if (i_load && boundary) begin
         shadow_data <= i_data;
         shadow_dp   <= i_dp;
         pend_valid  <= 1'b0;
      end else begin
         if (boundary && pend_valid) begin
            shadow_data <= pend_data;
            shadow_dp   <= pend_dp;
            pend_valid  <= 1'b0;
         end
         if (i_load) begin
            pend_data  <= i_data;
            pend_dp    <= i_dp;
            pend_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      slot_an = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (digit == DW'(d)) begin
            cur_nib    = shadow_data[4*d +: 4];
            cur_dp     = shadow_dp[d];
            slot_an[d] = 1'b1;
         end
      end
   end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lead_zero;
   logic                  zero_run;

   // A digit is leading-zero when it and every higher nibble are zero.
   always_comb begin
      lead_zero = '0;
      zero_run  = 1'b1;
      for (int d = NUM_DIGITS - 1; d > 0; d--) begin
         zero_run     = zero_run & (shadow_data[4*d +: 4] == 4'h0);
         lead_zero[d] = zero_run;
      end
   end

   assign suppress = |(lead_zero & slot_an);
`else
   assign suppress = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_an         <= {NUM_DIGITS{AN_INV}};
         o_seg        <= {7{SEG_INV}};
         o_dp         <= SEG_INV;
         o_frame_done <= 1'b0;
      end else begin
         o_frame_done <= boundary;
         if (blank) begin
            o_an  <= {NUM_DIGITS{AN_INV}};
            o_seg <= {7{SEG_INV}};
            o_dp  <= SEG_INV;
         end else begin
            o_an  <= slot_an ^ {NUM_DIGITS{AN_INV}};
            o_seg <= (suppress ? 7'h00 : decode(cur_nib)) ^ {7{SEG_INV}};
            o_dp  <= cur_dp ^ SEG_INV;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (active-high and active-low)
// checked each cycle against a frame-level reference model.
module tb_seven_seg_scan_driver;

   localparam int N  = 4;
   localparam int R  = 4;
   localparam int B  = 1;
   localparam int FR = N * R;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  dp = '0;

   logic [3:0]  h_an, l_an;
   logic [6:0]  h_seg, l_seg;
   logic        h_dp, l_dp, h_fd, l_fd;
   logic [25:0] got;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(
      .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
      .SEG_ACTIVE_LOW(1'b0), .ANODE_ACTIVE_LOW(1'b0)
   ) dut_h (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_load(load),
      .o_seg(h_seg), .o_dp(h_dp), .o_an(h_an), .o_frame_done(h_fd)
   );

   seven_seg_scan_driver #(
      .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
      .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1)
   ) dut_l (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp(dp), .i_load(load),
      .o_seg(l_seg), .o_dp(l_dp), .o_an(l_an), .o_frame_done(l_fd)
   );

   assign got = {h_an, h_seg, h_dp, h_fd, l_an, l_seg, l_dp, l_fd};

   int passed = 0;
   int total  = 0;

   logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                            7'h7D, 7'h07, 7'h7F, 7'h67, 7'h77, 7'h7C,
                            7'h39, 7'h5E, 7'h79, 7'h71};

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   // Reference: n is the position within the frame the next edge will see.
   int          n = 0;
   logic [15:0] shown = '0, pend = '0;
   logic [3:0]  sdp = '0, pdp = '0;
   logic        pv = 1'b0;
   logic [3:0]  e_an = '0;
   logic [6:0]  e_seg = '0;
   logic        e_dp = 1'b0, e_fd = 1'b0;

   function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d);
      logic [15:0] up;
      up = v >> (4 * d);
      if (LZ && d > 0 && up == 16'h0) return 7'h00;
      return lut[up[3:0]];
   endfunction

   function automatic logic [25:0] want();
      return {e_an, e_seg, e_dp, e_fd, ~e_an, ~e_seg, ~e_dp, e_fd};
   endfunction

   task automatic model_edge();
      int d, t;
      logic bnd;
      if (rst) begin
         n = 0; shown = '0; sdp = '0; pend = '0; pdp = '0; pv = 1'b0;
         e_an = '0; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
      end else begin
         d = (n / R) % N;
         t = n % R;
         bnd = (n == FR - 1);
         if (t < B) begin
            e_an = '0; e_seg = '0; e_dp = 1'b0;
         end else begin
            e_an = 4'(1 << d); e_seg = ref_seg(shown, d); e_dp = sdp[d];
         end
         e_fd = bnd;
         if (load && bnd) begin
            shown = data; sdp = dp; pv = 1'b0;
         end else begin
            if (bnd && pv) begin
               shown = pend; sdp = pdp; pv = 1'b0;
            end
            if (load) begin
               pend = data; pdp = dp; pv = 1'b1;
            end
         end
         n = (n + 1) % FR;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic align(input int target);
      int k;
      k = 0;
      while (n != target && k < 2 * FR) begin
         cyc();
         k++;
      end
      total++;
      if (n != target) $display("FAIL align target=%0d got=%0d", target, n);
      else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         cyc();
         total++;
         if ({h_an, h_seg, h_dp, h_fd} !== 13'h0 ||
             {l_an, l_seg, l_dp, l_fd} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset_hold got=%h want_h=0", got);
         else passed++;
      end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         total++;
         if (k == 0 ? (h_an !== 4'b0000 || h_seg !== 7'h00)
                    : (h_an !== 4'b0001 || h_seg !== 7'h3F))
            $display("FAIL reset_release k=%0d an=%b seg=%h", k, h_an, h_seg);
         else passed++;
         total++;
         if (got !== want()) $display("FAIL reset_model got=%h want=%h", got, want());
         else passed++;
      end
   endtask

   task automatic test_load_frame();
      logic [6:0] tbl [4] = '{7'h71, 7'h77, 7'h5B, 7'h06};
      int s, dd, pulses, last_fd;
      logic [3:0] xa;
      logic [6:0] xs;
      data = 16'h12AF; dp = 4'b0100; load = 1'b1;
      cyc();
      load = 1'b0; data = $urandom; dp = $urandom;
      align(0);
      pulses = 0; last_fd = -1;
      for (int k = 0; k < 2 * FR; k++) begin
         s = n;
         cyc();
         dd = s / R;
         xa = (s % R == 0) ? 4'b0000 : 4'(1 << dd);
         xs = (s % R == 0) ? 7'h00 : tbl[dd];
         total++;
         if (h_an !== xa || h_seg !== xs || h_dp !== (s % R != 0 && dd == 2) ||
             h_fd !== (s == FR - 1))
            $display("FAIL load_12af s=%0d an=%b seg=%h dp=%b fd=%b want an=%b seg=%h",
                     s, h_an, h_seg, h_dp, h_fd, xa, xs);
         else passed++;
         total++;
         if (got !== want()) $display("FAIL load_model got=%h want=%h", got, want());
         else passed++;
         if (h_fd) begin
            total++;
            if (last_fd >= 0 && k - last_fd != FR)
               $display("FAIL frame_period got=%0d want=%0d", k - last_fd, FR);
            else passed++;
            last_fd = k;
            pulses++;
         end
      end
      total++;
      if (pulses != 2) $display("FAIL frame_pulses got=%0d want=2", pulses);
      else passed++;
   endtask

   task automatic test_tear_free();
      int s;
      logic [15:0] v;
      align(5);
      data = 16'h1111; dp = 4'h0; load = 1'b1;
      cyc();
      load = 1'b0;
      for (int k = 0; k < 10 + FR; k++) begin
         s = n;
         cyc();
         if (s >= 9 && s <= 11 && k < 10) begin
            total++;
            if (h_seg !== 7'h5B) $display("FAIL tear_old s=%0d got=%h want=5B", s, h_seg);
            else passed++;
         end
         if (k >= 10 && s % R != 0) begin
            total++;
            if (h_seg !== 7'h06) $display("FAIL tear_new s=%0d got=%h want=06", s, h_seg);
            else passed++;
         end
         total++;
         if (got !== want()) $display("FAIL tear_model got=%h want=%h", got, want());
         else passed++;
      end
      align(FR - 1);
      v = 16'($urandom);
      data = v; dp = $urandom; load = 1'b1;
      cyc();
      load = 1'b0;
      for (int k = 0; k < FR; k++) begin
         s = n;
         cyc();
         if (s >= 1 && s <= 3) begin
            total++;
            if (h_seg !== lut[v[3:0]])
               $display("FAIL boundary_load s=%0d got=%h want=%h", s, h_seg, lut[v[3:0]]);
            else passed++;
         end
         total++;
         if (got !== want()) $display("FAIL boundary_model got=%h want=%h", got, want());
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int s;
      align(2);
      data = 16'h0003; load = 1'b1;
      cyc();
      data = 16'h0009;
      cyc();
      load = 1'b0;
      align(0);
      for (int k = 0; k < R; k++) begin
         s = n;
         cyc();
         total++;
         if (s != 0 && h_seg !== 7'h67)
            $display("FAIL back_to_back s=%0d got=%h want=67", s, h_seg);
         else if (got !== want())
            $display("FAIL b2b_model got=%h want=%h", got, want());
         else passed++;
      end
   endtask

   task automatic test_polarity();
      int s;
      data = 16'h0008; dp = 4'h0; load = 1'b1;
      cyc();
      load = 1'b0;
      align(0);
      for (int k = 0; k < FR; k++) begin
         s = n;
         cyc();
         if (s < R) begin
            total++;
            if (s == 0 ? (l_an !== 4'b1111 || l_seg !== 7'h7F)
                       : (l_an !== 4'b1110 || l_seg !== 7'h00))
               $display("FAIL polarity s=%0d an=%b seg=%h", s, l_an, l_seg);
            else passed++;
         end
         total++;
         if (got !== want()) $display("FAIL polarity_model got=%h want=%h", got, want());
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int s;
      logic [6:0] xs;
      data = 16'hBEEF; dp = 4'hF; load = 1'b1;
      cyc();
      load = 1'b0;
      align(0);
      align(9);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      total++;
      if ({h_an, h_seg, h_dp, h_fd} !== 13'h0 || l_an !== 4'hF || l_seg !== 7'h7F)
         $display("FAIL reset_mid got=%h want_h=0", got);
      else passed++;
      for (int k = 0; k < FR; k++) begin
         s = n;
         cyc();
         xs = (s % R == 0) ? 7'h00 : ((LZ && s >= R) ? 7'h00 : 7'h3F);
         total++;
         if (h_seg !== xs || h_dp !== 1'b0 || (s < R && s % R != 0 && h_an !== 4'b0001))
            $display("FAIL reset_rescan s=%0d seg=%h dp=%b want=%h", s, h_seg, h_dp, xs);
         else passed++;
         total++;
         if (got !== want()) $display("FAIL rescan_model got=%h want=%h", got, want());
         else passed++;
      end
   endtask

   task automatic test_leading_zero();
      logic [6:0] tbl [4];
      int s, dd;
      tbl[0] = 7'h3F; tbl[1] = 7'h6D;
      tbl[2] = LZ ? 7'h00 : 7'h3F;
      tbl[3] = LZ ? 7'h00 : 7'h3F;
      data = 16'h0050; dp = 4'b1000; load = 1'b1;
      cyc();
      load = 1'b0;
      align(0);
      for (int k = 0; k < FR; k++) begin
         s = n;
         cyc();
         dd = s / R;
         if (s % R != 0) begin
            total++;
            if (h_an !== 4'(1 << dd) || h_seg !== tbl[dd] || h_dp !== (dd == 3))
               $display("FAIL leading_zero d=%0d an=%b seg=%h want=%h", dd, h_an, h_seg, tbl[dd]);
            else passed++;
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         rst  = ($urandom_range(0, 63) == 0);
         load = ($urandom_range(0, 5) == 0);
         data = 16'($urandom);
         dp   = 4'($urandom);
         if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
         cyc();
         total++;
         if (got !== want()) $display("FAIL random k=%0d got=%h want=%h", k, got, want());
         else passed++;
      end
      rst = 1'b0; load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_frame();
      test_tear_free();
      test_back_to_back();
      test_polarity();
      test_reset_mid();
      test_leading_zero();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
